viterbi_traceback: RTL and testbench
====================================

# viterbi_traceback

Backpointer store and traceback stage. It sits directly downstream of the array of I Viterbi PEs. Each step it accepts the vector of per-state argmax indices (ψ[n][0..I-1]) that the PEs produce. On the final step it also takes the final δ vector, selects the best end state, and walks the stored backpointers in reverse. It emits the decoded state sequence one state per cycle, from step N-1 down to step 0.

## Interface
- I, 3, number of HMM states (≥2); SW = $clog2(I)
- W, 20, signed δ width (matches PE δ width)
- T_MAX, 16, max stored backpointer steps; CW = $clog2(T_MAX+1)
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- in_valid  in  1  backpointer beat valid
- in_ready  out  1  block accepts beats (registered)
- in_psi  in  I×SW  ψ[n][j] for j=0..I-1 (packed array [0:I-1])
- in_last  in  1  beat is final step N-1
- in_delta  in  I×W signed  δ[N-1][j]; sampled only on last/forced-last beat
- out_valid  out  1  decoded state valid (registered)
- out_ready  in  1  consumer accepts
- out_state  out  SW  decoded q[out_step]
- out_step  out  CW  step index n of out_state
- out_last  out  1  out_step==0 (final beat)
- err_ovf  out  1  sequence truncated at T_MAX

## Operation
- FSM: S_FILL, S_TRACE.
- Accept = in_valid && in_ready.
- S_FILL:
  - in_ready=1.
  - Each accept writes in_psi into mem[cnt] and increments cnt.
  - The first beat is step n=1. Sequences with N=1 are unsupported.
  - Accept with in_last → S_TRACE.
  - Accept with cnt==T_MAX-1 and !in_last → forced last: set err_ovf=1, then → S_TRACE.
  - On entry to S_TRACE: out_state ← argmax(in_delta), out_step ← cnt+1 (= L), out_valid ← 1, in_ready ← 0.
- Argmax: signed compare, strict >, ties → lowest index.
- S_TRACE:
  - On out handshake with out_step>0: out_state ← mem[out_step-1][out_state], out_step ← out_step-1.
  - On out handshake with out_last: out_valid ← 0, cnt ← 0, in_ready ← 1, → S_FILL.
- L stored beats yield L+1 output beats.
- in_valid is ignored in S_TRACE, and memory is untouched.
- err_ovf is cleared on the next accept in S_FILL. It is not cleared by completing the traceback.
- Reset: FSM=S_FILL, cnt=0, and in_ready, out_valid, out_state, out_step, out_last, err_ovf all 0. Memory is not reset.

## Timing
- in_ready rises on the first clk edge after rst deasserts.
- Last beat accepted at edge k → out_valid=1 from edge k. First output is visible in the cycle after the accept.
- Throughput: 1 output beat per cycle while out_ready=1.
- The gap from out_last handshake to the next in_ready=1 is 0 cycles: both are registered at the same edge.
- Output hold: while out_valid && !out_ready, out_state, out_step and out_last are stable.
- rst asserted mid-TRACE or mid-FILL: all outputs go to 0 asynchronously and the partial sequence is discarded.
- mem read is combinational from a register array (I·T_MAX·SW bits). No RAM latency.

## Structure
- viterbi_pkg:
  - FSM state enum.
  - Localparam helpers for SW/CW.
  - Shared between PE and traceback.
- Sub-module viterbi_argmax:
  - Combinational I-way signed argmax, lowest-index tie.
  - Reusable by the PE array.
- Top: FSM, counter, backpointer register file, output registers.

## Test plan
- **Basic traceback.** I=3, beats: ψ1={0,0,1}, ψ2={2,1,0}, ψ3={1,2,2} last, δ={-5,7,7}, out_ready=1.
  - Outputs (step,state) = (3,1),(2,2),(1,0),(0,0).
  - out_last only on the 4th beat; in_ready returns high in the same cycle.
- **Backpressure.** Same stimulus with out_ready low for 3 cycles after the 2nd output beat.
  - (2,2) holds stable for 3 cycles; the sequence is otherwise identical.
- **Overflow.** T_MAX=4, four beats all ψ={1,2,0} with no in_last, 4th δ={0,0,3}.
  - err_ovf=1.
  - Outputs (4,2),(3,0),(2,1),(1,2),(0,0).
  - err_ovf clears on the next accepted beat.
- **Reset mid-TRACE.** Assert rst after 2 output beats.
  - out_valid, in_ready and err_ovf drop to 0 immediately.
  - After release, in_ready=1 on the next edge; a rerun of the basic-traceback stimulus decodes correctly.
- **Input ignored during TRACE, plus signed extremes.** Drive in_valid=1 with junk ψ throughout TRACE.
  - Output is unaffected.
  - Next sequence: single last beat ψ={0,1,1}, δ={-524288,-524288,524287} → outputs (1,2),(0,1).

Source files
------------

// File: rtl/viterbi_traceback_pkg.sv
// Shared types and width helpers for the Viterbi PE array and traceback.
package viterbi_traceback_pkg;

  typedef enum logic {
    S_FILL,
    S_TRACE
  } fsm_e;

  function automatic int sw_of(input int i);
    return (i < 2) ? 1 : $clog2(i);
  endfunction

  function automatic int cw_of(input int t);
    return $clog2(t + 1);
  endfunction

  function automatic int aw_of(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/viterbi_traceback_if.sv
// Backpointer-in / decoded-state-out handshake bundle.
interface viterbi_traceback_if #(
  parameter int I     = 3,
  parameter int W     = 20,
  parameter int T_MAX = 16
);
  import viterbi_traceback_pkg::*;

  localparam int SW = sw_of(I);
  localparam int CW = cw_of(T_MAX);

  logic                    in_valid;
  logic                    in_ready;
  logic [0:I-1][SW-1:0]    in_psi;
  logic                    in_last;
  logic [0:I-1][W-1:0]     in_delta;
  logic                    out_valid;
  logic                    out_ready;
  logic [SW-1:0]           out_state;
  logic [CW-1:0]           out_step;
  logic                    out_last;
  logic                    err_ovf;

  modport master (
    output in_valid, in_psi, in_last, in_delta,
    output out_ready,
    input  in_ready, out_valid, out_state,
    input  out_step, out_last, err_ovf
  );

  modport slave (
    input  in_valid, in_psi, in_last, in_delta,
    input  out_ready,
    output in_ready, out_valid, out_state,
    output out_step, out_last, err_ovf
  );

endinterface

// File: rtl/viterbi_traceback_argmax.sv
// I-way signed argmax; ties resolve to the lowest index.
module viterbi_traceback_argmax #(
  parameter int I  = 3,
  parameter int W  = 20,
  parameter int SW = 2
) (
  input  logic [0:I-1][W-1:0] vec,
  output logic [SW-1:0]       idx
);

  logic signed [W-1:0] best;

  always_comb begin
    best = $signed(vec[0]);
    idx  = '0;
    for (int j = 1; j < I; j++) begin
      if ($signed(vec[j]) > best) begin
        best = $signed(vec[j]);
        idx  = SW'(j);
      end
    end
  end

endmodule

// File: rtl/viterbi_traceback.sv
// Backpointer store and traceback: fills psi vectors, then walks
// them backwards from the best final state, one state per cycle.
module viterbi_traceback
  import viterbi_traceback_pkg::*;
#(
  parameter int I     = 3,
  parameter int W     = 20,
  parameter int T_MAX = 16
) (
  input logic               clk,
  input logic               rst,
  viterbi_traceback_if.slave bus
);

  localparam int SW = sw_of(I);
  localparam int CW = cw_of(T_MAX);
  localparam int AW = aw_of(T_MAX);

  fsm_e          state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] mem [T_MAX][I];
  logic [SW-1:0] best;
  logic [SW-1:0] bp;
  logic [AW-1:0] rd_idx;
  logic          acc;
  logic          fin;
  logic          hs;

  assign acc    = bus.in_valid && bus.in_ready;
  assign fin    = bus.in_last || (cnt == CW'(T_MAX - 1));
  assign hs     = bus.out_valid && bus.out_ready;
  assign rd_idx = AW'(bus.out_step - 1'b1);
  assign bp     = mem[rd_idx][bus.out_state];

  viterbi_traceback_argmax #(
    .I  (I),
    .W  (W),
    .SW (SW)
  ) u_argmax (
    .vec (bus.in_delta),
    .idx (best)
  );

  // Register file: written only while filling, never reset.
  always_ff @(posedge clk) begin
    if (acc && state == S_FILL) begin
      for (int j = 0; j < I; j++) begin
        mem[cnt[AW-1:0]][j] <= bus.in_psi[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FILL;
      cnt           <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_state <= '0;
      bus.out_step  <= '0;
      bus.out_last  <= 1'b0;
      bus.err_ovf   <= 1'b0;
    end else begin
      unique case (state)
        S_FILL: begin
          bus.in_ready <= 1'b1;
          if (acc) begin
            cnt         <= cnt + 1'b1;
            bus.err_ovf <= 1'b0;
            if (fin) begin
              state         <= S_TRACE;
              bus.err_ovf   <= !bus.in_last;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              bus.out_state <= best;
              bus.out_step  <= cnt + 1'b1;
              bus.out_last  <= 1'b0;
            end
          end
        end
        S_TRACE: begin
          if (hs) begin
            if (bus.out_last) begin
              state         <= S_FILL;
              cnt           <= '0;
              bus.in_ready  <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              bus.out_state <= bp;
              bus.out_step  <= bus.out_step - 1'b1;
              bus.out_last  <= (bus.out_step == CW'(1));
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Randomized + directed bench for viterbi_traceback with a
// sequence-level traceback model and a per-cycle compare process.
module tb_viterbi_traceback;

  localparam int I  = 3;
  localparam int W  = 20;
  localparam int TM = 16;
  localparam int SW = 2;

  typedef logic [0:I-1][SW-1:0] psi_t;
  typedef logic [0:I-1][W-1:0]  delta_t;
  typedef struct {
    int step;
    int state;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int    nc = 0;
  int    nf = 0;
  psi_t  seq[$];
  beat_t exp_q[$];
  beat_t got[$];
  bit    exp_ovf = 1'b0;
  bit    last_ovf = 1'b0;

  viterbi_traceback_if #(.I(I), .W(W), .T_MAX(TM)) bus ();

  viterbi_traceback #(
    .I     (I),
    .W     (W),
    .T_MAX (TM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int ref_argmax(input delta_t d);
    int b = 0;
    for (int j = 1; j < I; j++)
      if ($signed(d[j]) > $signed(d[b])) b = j;
    return b;
  endfunction

  function automatic psi_t mk_psi(input int a, input int b, input int c);
    psi_t p;
    p[0] = SW'(a);
    p[1] = SW'(b);
    p[2] = SW'(c);
    return p;
  endfunction

  function automatic delta_t mk_delta(input int a, input int b, input int c);
    delta_t d;
    d[0] = W'(a);
    d[1] = W'(b);
    d[2] = W'(c);
    return d;
  endfunction

  function automatic psi_t rnd_psi();
    psi_t p;
    for (int j = 0; j < I; j++) p[j] = SW'($urandom_range(0, I - 1));
    return p;
  endfunction

  function automatic delta_t rnd_delta();
    delta_t d;
    int v;
    for (int j = 0; j < I; j++) begin
      if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 3)) - 1;
      else v = int'($urandom) >>> 12;
      d[j] = W'(v);
    end
    return d;
  endfunction

  task automatic chk(input bit ok, input string nm, input int g, input int w);
    nc++;
    if (!ok) begin
      nf++;
      $display("FAIL %s: got %0d want %0d", nm, g, w);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  endtask

  task automatic timeout(input string nm);
    nc++;
    nf++;
    $display("FAIL %s: timeout, got no progress want progress", nm);
    summary();
  endtask

  task automatic chk_beat(input int i, input int st, input int s);
    nc++;
    if (i >= got.size()) begin
      nf++;
      $display("FAIL lit_beat%0d: got none want (%0d,%0d)", i, st, s);
    end else if (got[i].step != st || got[i].state != s) begin
      nf++;
      $display("FAIL lit_beat%0d: got (%0d,%0d) want (%0d,%0d)",
               i, got[i].step, got[i].state, st, s);
    end
  endtask

  // Compare process: every valid output cycle against the model queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", int'(bus.out_step), -1);
        end else begin
          nc++;
          if (int'(bus.out_step) != exp_q[0].step ||
              int'(bus.out_state) != exp_q[0].state ||
              bus.out_last != (exp_q[0].step == 0)) begin
            nf++;
            $display("FAIL out_beat: got (%0d,%0d,l%0d) want (%0d,%0d)",
                     bus.out_step, bus.out_state, bus.out_last,
                     exp_q[0].step, exp_q[0].state);
          end
          chk(bus.err_ovf == exp_ovf, "err_ovf_trace",
              int'(bus.err_ovf), int'(exp_ovf));
          chk(bus.in_ready == 1'b0, "in_ready_trace",
              int'(bus.in_ready), 0);
          if (bus.out_ready) begin
            got.push_back(exp_q[0]);
            got[got.size()-1].step  = int'(bus.out_step);
            got[got.size()-1].state = int'(bus.out_state);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk(bus.out_valid == 0 && bus.in_ready == 0 && bus.err_ovf == 0 &&
        bus.out_step == 0 && bus.out_state == 0 && bus.out_last == 0,
        "rst_async",
        int'({bus.out_valid, bus.in_ready, bus.err_ovf, bus.out_last}), 0);
    exp_q.delete();
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk(bus.in_ready == 1'b1, "rst_release", int'(bus.in_ready), 1);
    last_ovf = 1'b0;
  endtask

  task automatic run_seq(input int n, input bit mk, input delta_t d,
                         input int st_at, input int st_len,
                         input int ab_at, input bit junk, input bit rr);
    int q;
    int t;
    int base;
    int stalled;
    bit acc;
    q = ref_argmax(d);
    exp_q.push_back('{n, q});
    for (int s = n; s >= 1; s--) begin
      q = int'(seq[s-1][q]);
      exp_q.push_back('{s - 1, q});
    end
    exp_ovf = !mk;
    chk(bus.err_ovf == last_ovf, "ovf_sticky",
        int'(bus.err_ovf), int'(last_ovf));
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      bus.in_psi   = seq[k];
      bus.in_last  = mk && (k == n - 1);
      bus.in_delta = d;
      acc = 1'b0;
      t = 0;
      while (!acc) begin
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        t++;
        if (t > 100) timeout("accept");
      end
      if (k < n - 1)
        chk(bus.err_ovf == 1'b0, "ovf_clear", int'(bus.err_ovf), 0);
      else
        chk(bus.out_valid == 1'b1 && bus.in_ready == 1'b0, "trace_entry",
            int'({bus.out_valid, bus.in_ready}), 2);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    base = got.size();
    stalled = 0;
    t = 0;
    while (exp_q.size() > 0) begin
      if (ab_at >= 0 && got.size() - base == ab_at) begin
        do_reset();
        return;
      end
      if (got.size() - base == st_at && stalled < st_len) begin
        bus.out_ready = 1'b0;
        stalled++;
      end else begin
        bus.out_ready = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.in_psi   = rnd_psi();
        bus.in_last  = 1'($urandom_range(0, 1));
        bus.in_delta = rnd_delta();
      end
      @(posedge clk);
      #1;
      t++;
      if (t > 300) timeout("drain");
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    chk(bus.in_ready == 1'b1 && bus.out_valid == 1'b0, "ready_return",
        int'({bus.in_ready, bus.out_valid}), 2);
    last_ovf = exp_ovf;
  endtask

  task automatic load_basic();
    seq.delete();
    seq.push_back(mk_psi(0, 0, 1));
    seq.push_back(mk_psi(2, 1, 0));
    seq.push_back(mk_psi(1, 2, 2));
  endtask

  task automatic chk_basic();
    chk(got.size() == 4, "basic_len", got.size(), 4);
    chk_beat(0, 3, 1);
    chk_beat(1, 2, 2);
    chk_beat(2, 1, 0);
    chk_beat(3, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    delta_t dbas;
    int n;
    bit mk;
    bus.in_valid  = 1'b0;
    bus.in_psi    = '0;
    bus.in_last   = 1'b0;
    bus.in_delta  = '0;
    bus.out_ready = 1'b0;
    dbas = mk_delta(-5, 7, 7);
    repeat (3) @(posedge clk);
    #1;
    chk(bus.in_ready == 0 && bus.out_valid == 0 && bus.err_ovf == 0 &&
        bus.out_step == 0 && bus.out_state == 0 && bus.out_last == 0,
        "reset_state",
        int'({bus.in_ready, bus.out_valid, bus.err_ovf, bus.out_last}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk(bus.in_ready == 1'b1, "ready_rise", int'(bus.in_ready), 1);

    load_basic();
    got.delete();
    run_seq(3, 1'b1, dbas, -1, 0, -1, 1'b0, 1'b0);
    chk_basic();

    got.delete();
    run_seq(3, 1'b1, dbas, 1, 3, -1, 1'b0, 1'b0);
    chk_basic();

    seq.delete();
    for (int k = 0; k < TM; k++) seq.push_back(mk_psi(1, 2, 0));
    got.delete();
    run_seq(TM, 1'b0, mk_delta(0, 0, 3), -1, 0, -1, 1'b0, 1'b0);
    chk(got.size() == TM + 1, "ovf_len", got.size(), TM + 1);
    chk_beat(0, 16, 2);
    chk_beat(1, 15, 0);
    chk_beat(2, 14, 1);
    chk_beat(3, 13, 2);
    chk_beat(16, 0, 0);

    load_basic();
    run_seq(3, 1'b1, dbas, -1, 0, 2, 1'b0, 1'b0);
    got.delete();
    run_seq(3, 1'b1, dbas, -1, 0, -1, 1'b0, 1'b0);
    chk_basic();

    got.delete();
    run_seq(3, 1'b1, dbas, -1, 0, -1, 1'b1, 1'b1);
    chk_basic();

    seq.delete();
    seq.push_back(mk_psi(0, 1, 1));
    got.delete();
    run_seq(1, 1'b1, mk_delta(-524288, -524288, 524287),
            -1, 0, -1, 1'b0, 1'b0);
    chk(got.size() == 2, "ext_len", got.size(), 2);
    chk_beat(0, 1, 2);
    chk_beat(1, 0, 1);

    for (int r = 0; r < 30; r++) begin
      n  = $urandom_range(1, TM);
      mk = (n < TM) ? 1'b1 : 1'($urandom_range(0, 1));
      seq.delete();
      for (int k = 0; k < n; k++) seq.push_back(rnd_psi());
      run_seq(n, mk, rnd_delta(), $urandom_range(0, n),
              $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)), 1'b1);
    end

    chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
    summary();
  end

endmodule
